// File: rtl/aer_pkg.sv
// Shared types and helpers for the AER output path.
//  aer_state_t : handshake FSM states of the output controller
//  eoi_addr()  : all-ones address used for the end-of-image event
package aer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO
  } aer_state_t;

  // All ones in the low 'width' bits; callers truncate to their address width.
  function automatic logic [31:0] eoi_addr(input int unsigned width);
    if (width >= 32) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/aer_out_ctrl_if.sv
// Sorter-side and AER-bus-side signals of the output controller.
//  NEXT_INDEX        sorted pixel index from the sorter
//  FOUND_NEXT_INDEX  1-cycle strobe, NEXT_INDEX valid
//  IMAGE_ENCODED     1-cycle strobe, sorter finished the image
//  AEROUT_ACK        asynchronous ACK from the receiver
//  AEROUT_ADDR       registered event address
//  AEROUT_REQ        registered 4-phase request
//  AEROUT_CTRL_BUSY  event in flight, sorter must hold
//  AEROUT_TIMEOUT    sticky ACK-timeout flag
// modport master: the controller; modport slave: sorter plus receiver.
interface aer_out_ctrl_if #(
  parameter int unsigned IMAGE_SIZE_BITS = 3
) ();

  logic [IMAGE_SIZE_BITS:0] NEXT_INDEX;
  logic                     FOUND_NEXT_INDEX;
  logic                     IMAGE_ENCODED;
  logic                     AEROUT_ACK;
  logic [IMAGE_SIZE_BITS:0] AEROUT_ADDR;
  logic                     AEROUT_REQ;
  logic                     AEROUT_CTRL_BUSY;
  logic                     AEROUT_TIMEOUT;

  modport master (
    input  NEXT_INDEX,
    input  FOUND_NEXT_INDEX,
    input  IMAGE_ENCODED,
    input  AEROUT_ACK,
    output AEROUT_ADDR,
    output AEROUT_REQ,
    output AEROUT_CTRL_BUSY,
    output AEROUT_TIMEOUT
  );

  modport slave (
    output NEXT_INDEX,
    output FOUND_NEXT_INDEX,
    output IMAGE_ENCODED,
    output AEROUT_ACK,
    input  AEROUT_ADDR,
    input  AEROUT_REQ,
    input  AEROUT_CTRL_BUSY,
    input  AEROUT_TIMEOUT
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
//  CLK  destination clock
//  RST  asynchronous active-high reset, clears both flops
//  d    asynchronous input
//  q    synchronised output, two CLK cycles of latency
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/aer_out_ctrl.sv
// AER output controller: turns each sorted pixel index into one event on an
// asynchronous 4-phase REQ/ACK bus, back-pressures the sorter with BUSY and
// optionally appends an end-of-image event (all-ones address).
//  CLK  clock
//  RST  asynchronous active-high reset
//  bus  master side of aer_out_ctrl_if (sorter inputs, AER outputs, ACK input)
module aer_out_ctrl
  import aer_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE      = 5,
  parameter int unsigned IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int unsigned ACK_TIMEOUT     = 255,
  parameter bit          EOI_EVENT       = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  aer_out_ctrl_if.master bus
);

  localparam int unsigned AW = IMAGE_SIZE_BITS + 1;
  // A zero-width timer is illegal, so ACK_TIMEOUT=0 still keeps one bit.
  localparam int unsigned TW = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);

  localparam logic [AW-1:0] EOI_ADDR   = AW'(eoi_addr(AW));
  localparam logic [TW:0]   TIMER_LAST = (TW + 1)'(ACK_TIMEOUT);

  aer_state_t    state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          req_q, req_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;
  logic          eoi_pending_q, eoi_pending_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [TW:0]   timer_inc;
  logic          timer_hit;
  logic          ack_s;

  sync_2ff u_ack_sync (
    .CLK (CLK),
    .RST (RST),
    .d   (bus.AEROUT_ACK),
    .q   (ack_s)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= 1'b0;
      eoi_pending_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
      eoi_pending_q <= eoi_pending_d;
      timer_q       <= timer_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    req_d         = req_q;
    busy_d        = busy_q;
    timeout_d     = timeout_q;
    eoi_pending_d = eoi_pending_q;
    timer_d       = timer_q;
    timer_inc     = {1'b0, timer_q} + 1'b1;
    // Compared against the incremented value so the abort lands exactly
    // ACK_TIMEOUT cycles after entering a wait state.
    timer_hit     = (ACK_TIMEOUT != 0) && (timer_inc == TIMER_LAST);

    unique case (state_q)
      IDLE: begin
        if (bus.FOUND_NEXT_INDEX) begin
          addr_d  = bus.NEXT_INDEX;
          busy_d  = 1'b1;
          state_d = SETUP;
        end else if (eoi_pending_q) begin
          addr_d        = EOI_ADDR;
          busy_d        = 1'b1;
          eoi_pending_d = 1'b0;
          state_d       = SETUP;
        end
      end
      // ADDR was loaded on the previous edge, so it is stable a full cycle before REQ.
      SETUP: begin
        req_d   = 1'b1;
        timer_d = '0;
        state_d = WAIT_ACK_HI;
      end
      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          timer_d = '0;
          state_d = WAIT_ACK_LO;
        end else if (timer_hit) begin
          timeout_d = 1'b1;
          req_d     = 1'b0;
          busy_d    = 1'b0;
          timer_d   = '0;
          state_d   = IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          timer_d = timer_inc[TW-1:0];
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_s) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (timer_hit) begin
          timeout_d = 1'b1;
          busy_d    = 1'b0;
          timer_d   = '0;
          state_d   = IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          timer_d = timer_inc[TW-1:0];
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Set after the state logic so a new IMAGE_ENCODED wins over the IDLE clear.
    if (EOI_EVENT && bus.IMAGE_ENCODED) begin
      eoi_pending_d = 1'b1;
    end
  end

  assign bus.AEROUT_ADDR      = addr_q;
  assign bus.AEROUT_REQ       = req_q;
  assign bus.AEROUT_CTRL_BUSY = busy_q;
  assign bus.AEROUT_TIMEOUT   = timeout_q;

endmodule
